// File: rtl/bin2bcd_if.sv
// Start/busy/done handshake and result bus between the display controller and bin2bcd_seq.
interface bin2bcd_if #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Result and overflow flag are held until the next completed conversion.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  bin2bcd_if.slave  bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  // Largest representable value 10^DIGITS-1; always fits in BCD_W bits.
  function automatic logic [BCD_W-1:0] max_val_f();
    logic [BCD_W:0] r;
    r = (BCD_W + 1)'(1);
    for (int i = 0; i < int'(DIGITS); i++) begin
      r = (BCD_W + 1)'(r * (BCD_W + 1)'(10));
    end
    r = r - (BCD_W + 1)'(1);
    return BCD_W'(r);
  endfunction

  localparam logic [BCD_W-1:0] MAX_VAL = max_val_f();

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_e;

  state_e             state_q,    state_d;
  logic [BIN_W-1:0]   bin_q,      bin_d;
  logic [BCD_W-1:0]   scr_q,      scr_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [BCD_W-1:0]   bcd_q,      bcd_d;
  logic               ovf_q,      ovf_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               done_q,     done_d;
  logic               busy_q,     busy_d;
  logic [BCD_W-1:0]   scr_adj;

  // Digit correction on pre-shift values, all digits in parallel.
  always_comb begin
    scr_adj = scr_q;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (scr_q[4*d +: 4] >= 4'd5) begin
        scr_adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d      = bus.bin_in;
          scr_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          // Overflow decided at latch time since the shift register is consumed.
          ovf_pend_d = (BCD_W'(bus.bin_in) > MAX_VAL);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, bin_d} = {scr_adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        bcd_d   = ovf_pend_q ? {DIGITS{4'd9}} : scr_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      ovf_pend_q <= ovf_pend_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq with hand-computed BCD results.
module tb_bin2bcd_seq;

  localparam int unsigned BIN_W  = 14;
  localparam int unsigned DIGITS = 4;
  localparam int          LAT    = BIN_W + 1;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bin2bcd_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a request at the current negedge and follow it to done.
  task automatic convert(input string name, input logic [13:0] val,
                         input logic [15:0] exp_bcd, input logic exp_ovf);
    int k;
    int busy_cnt;
    bus.start  = 1'b1;
    bus.bin_in = val;
    @(negedge clk);
    bus.start  = 1'b0;
    k = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && k < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      k++;
    end
    total++;
    if (k !== LAT) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, k, LAT);
    end
    total++;
    if (busy_cnt !== LAT) begin
      bad++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, LAT);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_at_done: got %b want 0", name, bus.busy);
    end
    total++;
    if (bus.bcd_out !== exp_bcd) begin
      bad++;
      $display("FAIL %s bcd: got %h want %h", name, bus.bcd_out, exp_bcd);
    end
    total++;
    if (bus.overflow !== exp_ovf) begin
      bad++;
      $display("FAIL %s overflow: got %b want %b", name, bus.overflow, exp_ovf);
    end
  endtask

  task automatic test_reset();
    int hold_bad;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.overflow, bus.bcd_out} !== 19'd0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b ovf=%b bcd=%h want all 0",
               bus.busy, bus.done, bus.overflow, bus.bcd_out);
    end
    rst_n = 1'b1;
    hold_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({bus.busy, bus.done, bus.overflow, bus.bcd_out} !== 19'd0) hold_bad++;
    end
    total++;
    if (hold_bad !== 0) begin
      bad++;
      $display("FAIL idle_hold: got %0d disturbed cycles want 0", hold_bad);
    end
  endtask

  task automatic test_basic();
    convert("basic_1234", 14'd1234, 16'h1234, 1'b0);
  endtask

  task automatic test_back_to_back();
    convert("b2b_0",    14'd0,    16'h0000, 1'b0);
    convert("b2b_9",    14'd9,    16'h0009, 1'b0);
    convert("b2b_10",   14'd10,   16'h0010, 1'b0);
    convert("b2b_9999", 14'd9999, 16'h9999, 1'b0);
  endtask

  task automatic test_overflow();
    convert("ovf_10000", 14'd10000, 16'h9999, 1'b1);
    convert("ovf_16383", 14'd16383, 16'h9999, 1'b1);
    convert("ovf_42",    14'd42,    16'h0042, 1'b0);
  endtask

  task automatic test_start_ignored();
    int k;
    int extra_done;
    int chg;
    repeat (2) @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 14'd500;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (4) @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 14'd777;
    @(negedge clk);
    bus.start  = 1'b0;
    k = 5;
    while (bus.done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k !== LAT) begin
      bad++;
      $display("FAIL ignore_latency: got %0d want %0d", k, LAT);
    end
    total++;
    if (bus.bcd_out !== 16'h0500) begin
      bad++;
      $display("FAIL ignore_bcd: got %h want 0500", bus.bcd_out);
    end
    extra_done = 0;
    chg = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra_done++;
      if (bus.bcd_out !== 16'h0500) chg++;
    end
    total++;
    if (extra_done !== 0) begin
      bad++;
      $display("FAIL ignore_no_second: got %0d busy/done cycles want 0", extra_done);
    end
    total++;
    if (chg !== 0) begin
      bad++;
      $display("FAIL ignore_hold: got %0d changed cycles want 0", chg);
    end
  endtask

  task automatic test_reset_mid();
    int dn;
    bus.start  = 1'b1;
    bus.bin_in = 14'd4321;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.overflow, bus.bcd_out} !== 19'd0) begin
      bad++;
      $display("FAIL midreset_clear: got busy=%b done=%b ovf=%b bcd=%h want all 0",
               bus.busy, bus.done, bus.overflow, bus.bcd_out);
    end
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
    end
    total++;
    if (dn !== 0) begin
      bad++;
      $display("FAIL midreset_no_done: got %0d busy/done cycles want 0", dn);
    end
    convert("after_reset_4321", 14'd4321, 16'h4321, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) producing the packed 4-digit BCD word that feeds the seven-segment digit decoder. It sits between the reaction-time millisecond counter and the display path, converting a latched binary value on request and holding the result until the next completion. A start/busy/done handshake lets the controller request a new conversion whenever the measured time changes.

## Interface
- BIN_W, 14, width of the binary input; must be ≥ 4 and ≤ 4*DIGITS.
- DIGITS, 4, number of BCD digits produced; output width 4*DIGITS.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request, sampled on the rising edge; honoured only when idle.
- bin_in  input  BIN_W  unsigned binary value, latched on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse: bcd_out and overflow updated.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 in [3:0], most significant digit in the top nibble.
- overflow  output  1  latched input exceeded 10^DIGITS−1; updated together with bcd_out.

## Operation
- States: IDLE, SHIFT, FIN.
- IDLE: on start=1, latch bin_in into the shift register, clear the BCD scratch register, load the bit counter with BIN_W, and go to SHIFT. On start=0, stay in IDLE.
- SHIFT, each cycle:
  - For every scratch digit ≥ 5, add 3 to it (all digits evaluated in parallel on pre-shift values).
  - Shift {scratch, binary} left by one bit, with the binary MSB entering scratch bit 0.
  - Decrement the counter. After the BIN_W-th shift, go to FIN.
- FIN:
  - If the latched value > 10^DIGITS−1, load bcd_out with all digits = 9 and set overflow=1.
  - Otherwise load bcd_out from scratch and set overflow=0.
  - Pulse done and go to IDLE.
- start while busy (SHIFT or FIN) is ignored. The in-flight operand is unaffected and no request is queued.
- bcd_out and overflow hold their values between completions. Only FIN changes them.
- Overflow comparison is unsigned at the full BIN_W width against the elaborated constant 10^DIGITS−1.
- Scratch digits never exceed 9 after any shift. Digits that receive no input bits stay 0.

## Timing
- Reset (asynchronous, while rst_n=0): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, scratch and counter cleared.
- Reset asserted mid-conversion aborts it. No done pulse is produced and bcd_out returns to 0.
- Edge N accepts start. busy=1 from after edge N through the cycle ending at edge N+BIN_W+1.
- Shifts occur on edges N+1 … N+BIN_W. The FIN action occurs on edge N+BIN_W+1.
- After edge N+BIN_W+1: done=1 for exactly one cycle, busy=0, new bcd_out/overflow visible.
- Latency from accepting edge to done: BIN_W+1 clocks (15 for defaults).
- start may be asserted during the done cycle and is accepted on the next edge. Minimum period between conversions is BIN_W+2 clocks (16 for defaults).
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset then idle: rst_n low → bcd_out=0x0000, busy=0, done=0, overflow=0. Without start, the outputs hold for 50 cycles.
- bin_in=1234, start one cycle → done exactly 15 clocks after the accepting edge, bcd_out=0x1234, overflow=0, busy high for 15 cycles.
- Boundary values back-to-back:
  - 0 → 0x0000.
  - 9 → 0x0009.
  - 10 → 0x0010.
  - 9999 → 0x9999, overflow=0.
  - Each start is issued in the done cycle, and acceptance occurs every 16 clocks.
- Overflow:
  - 10000 → 0x9999, overflow=1.
  - 16383 → 0x9999, overflow=1.
  - A following 42 → 0x0042, overflow=0.
- start pulsed with bin_in=777 mid-conversion of 500 → result 0x0500 at the original time, no second done, bcd_out stays 0x0500 afterwards.
- rst_n pulsed low at shift 7 of a 4321 conversion → outputs clear immediately, no done pulse. A new 4321 request converts correctly to 0x4321.
